// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, baud codes, divisor helper, receiver FSM states.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  // Line rate in bit/s for a baud code; unused codes fall back to 9600.
  function automatic int unsigned baud_rate(input logic [2:0] code);
    case (code)
      BAUD_19200:  return 19200;
      BAUD_38400:  return 38400;
      BAUD_57600:  return 57600;
      BAUD_115200: return 115200;
      default:     return 9600;
    endcase
  endfunction

  // Oversampling tick divisor, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input logic [2:0]  code,
                                           input int unsigned os);
    int unsigned den;
    den = baud_rate(code) * os;
    return (clk_freq + den / 2) / den;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator with a baud code latched on load.
// Ports: clk, rst_n; load (clears counter, latches baud_set); baud_set (rate code);
//        tick_c (combinational one-cycle tick when the counter reaches DIV-1).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] baud_set,
  output logic       tick_c
);

  // 9600 is the slowest rate, so its divisor sizes the counter.
  localparam int unsigned DIV_MAX = baud_div(CLK_FREQ, BAUD_9600, OVERSAMPLE);
  localparam int unsigned CW      = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;

  localparam logic [CW-1:0] LAST_9600   = CW'(baud_div(CLK_FREQ, BAUD_9600,   OVERSAMPLE) - 1);
  localparam logic [CW-1:0] LAST_19200  = CW'(baud_div(CLK_FREQ, BAUD_19200,  OVERSAMPLE) - 1);
  localparam logic [CW-1:0] LAST_38400  = CW'(baud_div(CLK_FREQ, BAUD_38400,  OVERSAMPLE) - 1);
  localparam logic [CW-1:0] LAST_57600  = CW'(baud_div(CLK_FREQ, BAUD_57600,  OVERSAMPLE) - 1);
  localparam logic [CW-1:0] LAST_115200 = CW'(baud_div(CLK_FREQ, BAUD_115200, OVERSAMPLE) - 1);

  logic [2:0]    code_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] last_c;

  // Rate code is frozen for the duration of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    code_q <= 3'd0;
    else if (load) code_q <= baud_set;
  end

  // Terminal count for the latched rate.
  always_comb begin
    last_c = LAST_9600;
    case (code_q)
      BAUD_19200:  last_c = LAST_19200;
      BAUD_38400:  last_c = LAST_38400;
      BAUD_57600:  last_c = LAST_57600;
      BAUD_115200: last_c = LAST_115200;
      default:     last_c = LAST_9600;
    endcase
  end

  // Free-running 0..DIV-1 counter, realigned to the start edge by load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt_q <= '0;
    else if (load || cnt_q == last_c) cnt_q <= '0;
    else                              cnt_q <= cnt_q + CW'(1);
  end

  assign tick_c = (cnt_q == last_c);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampled 3-sample majority vote,
// configurable data width / parity / stop bits, runtime baud select.
// Ports: sys_clk, rst_n; baud_set (rate code, latched at start); uart_rx (serial line);
//        data_byte (last word); rx_done (frame-complete pulse); parity_err, frame_err,
//        break_det (status of last frame, valid with rx_done).
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic [2:0]           baud_set,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] data_byte,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = 4;

  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PAR_INV   = (PARITY == PAR_ODD);

  state_t               state, state_nxt;
  logic                 rx_meta, rx_sync, rx_prev;
  logic                 tick_c;
  logic [SW-1:0]        s_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 samp_lo, samp_mid;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_q, ferr_q, ones_q;

  logic start_c, vote_pt_c, bit_end_c, vote_c;
  logic shift_c, par_c, stop_c, done_c;

  // Synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  uart_baud_tick #(
    .CLK_FREQ   (CLK_FREQ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk      (sys_clk),
    .rst_n    (rst_n),
    .load     (start_c),
    .baud_set (baud_set),
    .tick_c   (tick_c)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-bit strobes.
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    shift_c   = 1'b0;
    par_c     = 1'b0;
    stop_c    = 1'b0;
    done_c    = 1'b0;
    vote_pt_c = tick_c && (s_cnt == S_HI);
    bit_end_c = tick_c && (s_cnt == S_LAST);
    vote_c    = (samp_lo & samp_mid) | (samp_lo & rx_sync) | (samp_mid & rx_sync);
    case (state)
      ST_IDLE: begin
        if (rx_prev && !rx_sync) begin
          start_c   = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        // A start bit that votes high was a glitch.
        if (vote_pt_c && vote_c) state_nxt = ST_IDLE;
        else if (bit_end_c)      state_nxt = ST_DATA;
      end
      ST_DATA: begin
        shift_c = vote_pt_c;
        if (bit_end_c && bit_cnt == DATA_LAST)
          state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        par_c = vote_pt_c;
        if (bit_end_c) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        // Leave on the last stop vote, half a bit early, to absorb rate mismatch.
        stop_c = vote_pt_c;
        if (vote_pt_c && bit_cnt == STOP_LAST) begin
          done_c    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sample index within the current bit.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                               s_cnt <= '0;
    else if (start_c || state_nxt == ST_IDLE) s_cnt <= '0;
    else if (tick_c)                          s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + SW'(1);
  end

  // Bit index within the current field; restarts whenever the state changes.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)         bit_cnt <= '0;
    else if (start_c)   bit_cnt <= '0;
    else if (bit_end_c) bit_cnt <= (state_nxt != state) ? '0 : bit_cnt + BW'(1);
  end

  // First two of the three vote samples; the third is the live line.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_lo  <= 1'b0;
      samp_mid <= 1'b0;
    end else if (tick_c) begin
      if (s_cnt == S_LO)  samp_lo  <= rx_sync;
      if (s_cnt == S_MID) samp_mid <= rx_sync;
    end
  end

  // Shift register and per-frame error accumulators.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      par_err_q <= 1'b0;
      ferr_q    <= 1'b0;
      ones_q    <= 1'b0;
    end else if (start_c) begin
      par_err_q <= 1'b0;
      ferr_q    <= 1'b0;
      ones_q    <= 1'b0;
    end else begin
      if (shift_c)                     shreg     <= {vote_c, shreg[DATA_BITS-1:1]};
      if (par_c)                       par_err_q <= (^shreg) ^ vote_c ^ PAR_INV;
      if (stop_c && !vote_c)           ferr_q    <= 1'b1;
      if (shift_c || par_c || stop_c)  ones_q    <= ones_q | vote_c;
    end
  end

  // Frame results, updated together with rx_done and held until the next one.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_done    <= 1'b0;
      data_byte  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      rx_done <= done_c;
      if (done_c) begin
        data_byte  <= shreg;
        parity_err <= par_err_q;
        frame_err  <= ferr_q | ~vote_c;
        break_det  <= ~(ones_q | vote_c);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: an 8N1 instance and an 8E1 instance, directed
// scenarios plus randomized frames, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int unsigned CLK_FREQ = 3_686_400;
  localparam int unsigned OS       = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
    logic       b;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] baud0, baud1;
  logic       line0, line1;
  logic [7:0] data0, data1;
  logic       done0, done1, perr0, perr1, ferr0, ferr1, brk0, brk1;

  always #5 clk = ~clk;

  uart_rx_frame #(
    .CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut (
    .sys_clk(clk), .rst_n(rst_n), .baud_set(baud0), .uart_rx(line0),
    .data_byte(data0), .rx_done(done0), .parity_err(perr0), .frame_err(ferr0),
    .break_det(brk0)
  );

  uart_rx_frame #(
    .CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) dut_p (
    .sys_clk(clk), .rst_n(rst_n), .baud_set(baud1), .uart_rx(line1),
    .data_byte(data1), .rx_done(done1), .parity_err(perr1), .frame_err(ferr1),
    .break_det(brk1)
  );

  rec_t q_obs0[$], q_obs1[$], q_exp0[$], q_exp1[$];
  rec_t last0, last1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  // Record every completed frame seen on either receiver.
  always @(negedge clk) begin
    if (done0) q_obs0.push_back(rec_t'({data0, perr0, ferr0, brk0}));
    if (done1) q_obs1.push_back(rec_t'({data1, perr1, ferr1, brk1}));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit period in clocks for a baud code, from the nominal rate.
  function automatic int bit_len(input int code);
    int baud;
    case (code)
      1:       baud = 19200;
      2:       baud = 38400;
      3:       baud = 57600;
      4:       baud = 115200;
      default: baud = 9600;
    endcase
    return int'(OS) * ((int'(CLK_FREQ) + baud * int'(OS) / 2) / (baud * int'(OS)));
  endfunction

  // Expected receiver report for a frame; parity (when present) is even.
  function automatic rec_t model(input logic [7:0] d, input bit has_par, input logic pb,
                                 input logic stop);
    rec_t r;
    r.d = d;
    r.p = has_par && ((($countones(d) + int'(pb)) % 2) == 1);
    r.f = !stop;
    r.b = (d == 8'h00) && (!has_par || !pb) && !stop;
    return r;
  endfunction

  // Line levels in transmission order, bit 0 first.
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input bit has_par,
                                             input logic pb, input logic stop);
    logic [15:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (has_par) begin
      f[9]  = pb;
      f[10] = stop;
    end else begin
      f[9]  = stop;
    end
    return f;
  endfunction

  task automatic send_bits(input bit sel, input logic [15:0] bits, input int n, input int bc);
    for (int i = 0; i < n; i++) begin
      if (sel) line1 = bits[i];
      else     line0 = bits[i];
      repeat (bc) @(negedge clk);
    end
  endtask

  // sel=1 targets the even-parity receiver.
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic pb,
                            input logic stop, input int bc);
    if (sel) q_exp1.push_back(model(d, 1'b1, pb, stop));
    else     q_exp0.push_back(model(d, 1'b0, pb, stop));
    send_bits(sel, frame_bits(d, sel, pb, stop), sel ? 11 : 10, bc);
    if (sel) line1 = 1'b1;
    else     line0 = 1'b1;
  endtask

  // 8N1 frame with every bit edge displaced by up to +/-3% of a bit.
  task automatic send_jitter(input logic [7:0] d, input int bc);
    logic [15:0] fb;
    int jp, jn, jmax;
    fb   = frame_bits(d, 1'b0, 1'b0, 1'b1);
    jmax = (bc * 3) / 100;
    jp   = 0;
    q_exp0.push_back(model(d, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 10; i++) begin
      jn = (i == 9) ? 0 : int'($urandom_range(2 * jmax)) - jmax;
      line0 = fb[i];
      repeat (bc + jn - jp) @(negedge clk);
      jp = jn;
    end
    line0 = 1'b1;
  endtask

  // Compare received frames against expectations, then the held outputs.
  task automatic compare_frames(input string tag, input bit sel);
    rec_t o, e;
    int   no, ne;
    repeat (8) @(negedge clk);
    no = sel ? q_obs1.size() : q_obs0.size();
    ne = sel ? q_exp1.size() : q_exp0.size();
    check({tag, " done count"}, no, ne);
    while (no > 0 && ne > 0) begin
      if (sel) begin
        o = q_obs1.pop_front(); e = q_exp1.pop_front(); last1 = e;
      end else begin
        o = q_obs0.pop_front(); e = q_exp0.pop_front(); last0 = e;
      end
      check({tag, " data"},   o.d, e.d);
      check({tag, " parity"}, o.p, e.p);
      check({tag, " frame"},  o.f, e.f);
      check({tag, " break"},  o.b, e.b);
      no--;
      ne--;
    end
    if (sel) begin
      q_obs1.delete(); q_exp1.delete();
      check({tag, " hold"}, {data1, perr1, ferr1, brk1}, last1);
    end else begin
      q_obs0.delete(); q_exp0.delete();
      check({tag, " hold"}, {data0, perr0, ferr0, brk0}, last0);
    end
  endtask

  initial begin
    int          bc, bc9, code;
    logic [7:0]  d;
    logic        pb, stop;
    logic [15:0] fb;

    rst_n = 1'b0;
    line0 = 1'b1;
    line1 = 1'b1;
    baud0 = 3'd4;
    baud1 = 3'd4;
    last0 = '0;
    last1 = '0;
    repeat (5) @(negedge clk);
    check("reset asserted dut",   {data0, perr0, ferr0, brk0, done0}, 32'h0);
    check("reset asserted dut_p", {data1, perr1, ferr1, brk1, done1}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("reset released dut",   {data0, perr0, ferr0, brk0, done0}, 32'h0);

    // Back-to-back 8N1 frames at 115200.
    bc = bit_len(4);
    send_frame(1'b0, 8'h55, 1'b0, 1'b1, bc);
    send_frame(1'b0, 8'hA3, 1'b0, 1'b1, bc);
    compare_frames("b2b 8N1", 1'b0);

    // Even parity: good then bad parity bit.
    send_frame(1'b1, 8'hA3, 1'b0, 1'b1, bc);
    compare_frames("even parity ok", 1'b1);
    send_frame(1'b1, 8'hA3, 1'b1, 1'b1, bc);
    compare_frames("even parity bad", 1'b1);

    // Short low glitch at 9600 must be rejected, then a real frame received.
    baud0 = 3'd0;
    bc9   = bit_len(0);
    line0 = 1'b0;
    repeat (3 * bc9 / int'(OS)) @(negedge clk);
    line0 = 1'b1;
    repeat (2 * bc9) @(negedge clk);
    compare_frames("glitch", 1'b0);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1, bc9);
    compare_frames("after glitch", 1'b0);

    // Stop bit low, then a held-low line (break) of two frame times.
    baud0 = 3'd4;
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, bc);
    repeat (bc) @(negedge clk);
    compare_frames("stop low", 1'b0);
    q_exp0.push_back(model(8'h00, 1'b0, 1'b0, 1'b0));
    line0 = 1'b0;
    repeat (20 * bc) @(negedge clk);
    line0 = 1'b1;
    repeat (2 * bc) @(negedge clk);
    compare_frames("break", 1'b0);

    // Reset in the middle of data bit 4 of 0xF0 aborts the frame.
    send_bits(1'b0, frame_bits(8'hF0, 1'b0, 1'b0, 1'b1), 5, bc);
    line0 = 1'b1;
    repeat (bc / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid-frame reset dut",   {data0, perr0, ferr0, brk0, done0}, 32'h0);
    check("mid-frame reset dut_p", {data1, perr1, ferr1, brk1, done1}, 32'h0);
    rst_n = 1'b1;
    last0 = '0;
    last1 = '0;
    repeat (5 * bc) @(negedge clk);
    compare_frames("aborted frame", 1'b0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1, bc);
    compare_frames("after reset", 1'b0);

    // Baud code changed mid-frame; next frame at 9600 with edge jitter.
    d  = 8'($urandom);
    fb = frame_bits(d, 1'b0, 1'b0, 1'b1);
    q_exp0.push_back(model(d, 1'b0, 1'b0, 1'b1));
    send_bits(1'b0, fb, 5, bc);
    baud0 = 3'd0;
    fb    = fb >> 5;
    send_bits(1'b0, fb, 5, bc);
    send_jitter(8'h99, bc9);
    compare_frames("baud switch + jitter", 1'b0);

    // Randomized 8N1 frames: any baud code, occasional bad stop bit.
    for (int k = 0; k < 6; k++) begin
      code  = int'($urandom_range(7));
      baud0 = 3'(code);
      d     = 8'($urandom);
      stop  = ($urandom_range(3) != 0);
      send_frame(1'b0, d, 1'b0, stop, bit_len(code));
      repeat (bit_len(code)) @(negedge clk);
      compare_frames("random 8N1", 1'b0);
    end

    // Randomized even-parity frames with random parity bits.
    for (int k = 0; k < 4; k++) begin
      d  = 8'($urandom);
      pb = 1'($urandom_range(1));
      send_frame(1'b1, d, pb, 1'b1, bc);
      repeat (bc) @(negedge clk);
      compare_frames("random 8E1", 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
